// File: rtl/therm2bin_encoder.sv
// rtl/therm2bin_encoder.sv - two-stage 256-bit thermometer to 8-bit binary encoder
module therm2bin_encoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [255:0]         din,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           dout,
  output logic                 err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_cnt_clr
);

  logic                 r_s1_valid;
  logic [4:0]           r_s1_pc [16];
  logic                 r_s1_legal;
  logic                 r_s2_valid;
  logic [7:0]           r_dout;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [4:0]           w_pc [16];
  logic                 w_legal;
  logic [8:0]           w_sum;
  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic                 w_out_xfer;

  // A stage moves when it is empty or its consumer takes its word this cycle
  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_out_xfer = r_s2_valid && out_ready;

  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign dout      = r_dout;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

  // Sixteen 16-bit slices counted independently; a rising step (0 below a 1) anywhere is a bubble
  always_comb begin
    for (int g = 0; g < 16; g++) begin
      w_pc[g] = '0;
      for (int b = 0; b < 16; b++) begin
        w_pc[g] = w_pc[g] + {4'd0, din[g*16+b]};
      end
    end
    w_legal = din[0] && !(|(din[255:1] & ~din[254:0]));
  end

  // Full 9-bit popcount so that 256 ones stays distinguishable from zero ones
  always_comb begin
    w_sum = '0;
    for (int g = 0; g < 16; g++) begin
      w_sum = w_sum + {4'd0, r_s1_pc[g]};
    end
  end

  // Stage 1: partial popcounts and legality
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_legal <= 1'b0;
      for (int g = 0; g < 16; g++) begin
        r_s1_pc[g] <= '0;
      end
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_legal <= w_legal;
        for (int g = 0; g < 16; g++) begin
          r_s1_pc[g] <= w_pc[g];
        end
      end
    end
  end

  // Stage 2: popcount-1 (low 8 bits; an all-zero word reports 0) and the error flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s2_valid <= 1'b0;
      r_dout     <= '0;
      r_err      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_dout <= (w_sum == 9'd0) ? 8'd0 : (w_sum[7:0] - 8'd1);
        r_err  <= !r_s1_legal;
      end
    end
  end

  // Saturating count of delivered illegal words; clear has priority
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_cnt <= '0;
    end else if (err_cnt_clr) begin
      r_err_cnt <= '0;
    end else if (w_out_xfer && r_err && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_therm2bin_encoder.sv
// tb/tb_therm2bin_encoder.sv - randomized and directed self-checking bench for therm2bin_encoder
module tb_therm2bin_encoder;

  localparam int W = 2;

  logic           clk = 1'b0;
  logic           resetn = 1'b1;
  logic [255:0]   din = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [7:0]     dout;
  logic           err;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   err_cnt;
  logic           err_cnt_clr = 1'b0;

  always #5 clk = ~clk;

  therm2bin_encoder #(.ERR_CNT_W(W)) u_dut (
    .clk(clk), .resetn(resetn), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .dout(dout), .err(err), .out_valid(out_valid), .out_ready(out_ready),
    .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr)
  );

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         cyc;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  logic [W-1:0] m_cnt = '0;
  int           n_chk = 0;
  int           n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model(input logic [255:0] w, output logic [7:0] d, output logic e);
    int cnt;
    logic [255:0] ones;
    ones = '1;
    cnt = 0;
    for (int i = 0; i < 256; i++) cnt += int'(w[i]);
    if (cnt == 0) begin
      d = 8'd0;
      e = 1'b1;
    end else begin
      d = 8'(cnt - 1);
      e = (w != (ones >> (256 - cnt)));
    end
  endfunction

  function automatic logic [255:0] code(input int v);
    logic [255:0] ones;
    ones = '1;
    return ones >> (255 - v);
  endfunction

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    case ($urandom % 4)
      0: w = code(int'($urandom_range(0, 255)));
      1: begin
        w = code(int'($urandom_range(0, 255)));
        w[$urandom_range(0, 255)] ^= 1'b1;
      end
      2: w = ($urandom % 2 == 0) ? '0 : code(255);
      default: for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
    endcase
    return w;
  endfunction

  // Every cycle: compare outputs, occupancy and error count against the queue model, then advance it
  always @(negedge clk) begin : mon
    exp_t h;
    exp_t n;
    logic ot;
    logic exp_ov;
    cyc++;
    if (!resetn) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_dout", dout, 0);
      chk("rst_err", err, 0);
      chk("rst_err_cnt", err_cnt, 0);
    end else begin
      exp_ov = (q.size() > 0) && (q[0].cyc <= cyc - 2);
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("err_cnt", err_cnt, m_cnt);
      ot = 1'b0;
      h.e = 1'b0;
      if (out_valid && q.size() > 0) begin
        chk("dout", dout, q[0].d);
        chk("err", err, q[0].e);
        if (out_ready) begin
          ot = 1'b1;
          h = q.pop_front();
        end
      end
      if (err_cnt_clr) m_cnt = '0;
      else if (ot && h.e && !(&m_cnt)) m_cnt = m_cnt + 1'b1;
      if (in_valid && in_ready) begin
        model(din, n.d, n.e);
        n.cyc = cyc;
        q.push_back(n);
      end
    end
  end

  task automatic send1(input logic [255:0] w, input logic [7:0] ed, input logic ee);
    @(posedge clk); #1;
    din = w; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_s1_out_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_out_valid", out_valid, 1);
    chk("lat_dout", dout, ed);
    chk("lat_err", err, ee);
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; err_cnt_clr = 1'b0;
    for (int c = 0; c < 20 && q.size() > 0; c++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [255:0] bp [3];
    int idx;
    logic acc;

    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;

    // legal boundaries
    send1(256'h1, 8'd0, 1'b0);
    send1(code(255), 8'd255, 1'b0);
    send1(256'hFF, 8'd7, 1'b0);

    // illegal words and counter
    send1(256'h0, 8'd0, 1'b1);
    send1(256'h5, 8'd1, 1'b1);
    @(posedge clk); #1;
    chk("err_cnt_two", err_cnt, 2);
    for (int k = 0; k < 5; k++) send1(256'h0, 8'd0, 1'b1);
    @(posedge clk); #1;
    chk("err_cnt_sat", err_cnt, 3);

    // clear coinciding with an error transfer
    din = 256'h0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("clr_pre_out_valid", out_valid, 1);
    err_cnt_clr = 1'b1;
    @(posedge clk); #1;
    err_cnt_clr = 1'b0;
    chk("clr_wins", err_cnt, 0);
    drain();

    // back-to-back sweep of every legal code
    out_ready = 1'b1;
    for (int c = 0; c < 258; c++) begin
      @(posedge clk); #1;
      if (c < 256) begin
        din = code(c); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 2) chk("sweep", {out_valid, err, dout}, {1'b1, 1'b0, 8'(c - 2)});
    end
    drain();

    // back-pressure: 3 words offered, consumer stalled for 5 cycles
    bp[0] = code(10); bp[1] = code(200); bp[2] = 256'h0;
    out_ready = 1'b0; idx = 0; acc = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (acc) idx++;
      in_valid = (idx < 3);
      if (idx < 3) din = bp[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    @(posedge clk); #1;
    if (acc) idx++;
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_dout_held", dout, 8'd10);
    out_ready = 1'b1;
    in_valid = (idx < 3);
    if (idx < 3) din = bp[idx];
    for (int c = 0; c < 20 && idx < 3; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      in_valid = (idx < 3);
      if (idx < 3) din = bp[idx];
    end
    chk("bp_all_accepted", idx, 3);
    drain();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid = ($urandom % 4) != 0;
      din = rand_word();
      out_ready = ($urandom % 3) != 0;
      err_cnt_clr = ($urandom % 50) == 0;
    end
    drain();

    // reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1; din = code(42);
    repeat (3) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    q.delete();
    m_cnt = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    repeat (5) @(posedge clk);

    // first word after reset accepted on the first edge
    #1;
    din = code(99); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_out_valid", out_valid, 1);
    chk("post_rst_dout", dout, 8'd99);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
